// File: rtl/shift_cmd_sequencer_if.sv
// Handshake and shifter bundle between the command sequencer, its producer/consumer
// and the external barrel shifter.
interface shift_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [4:0]  cmd_amt;
    logic [31:0] cmd_data;
    logic        sh_dir;
    logic [4:0]  sh_amt;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [15:0] res_count;

    modport master (
        output cmd_valid, cmd_dir, cmd_amt, cmd_data, res_ready, d_out,
        input  cmd_ready, sh_dir, sh_amt, d_in, res_valid, res_data, res_count
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_amt, cmd_data, res_ready, d_out,
        output cmd_ready, sh_dir, sh_amt, d_in, res_valid, res_data, res_count
    );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Queues shift commands, issues them one at a time to an external barrel shifter
// and hands the captured results to a consumer with a valid/ready handshake.
module shift_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    shift_cmd_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [37:0]     mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   occ_r;

    logic            sh_dir_r;
    logic [4:0]      sh_amt_r;
    logic [31:0]     d_in_r;
    logic            res_valid_r;
    logic [31:0]     res_data_r;
    logic [15:0]     res_count_r;

    logic            push_s;
    logic            pop_s;
    logic            capture_s;
    logic            res_clr_s;
    logic            fifo_ne_s;
    logic            res_hs_s;
    logic [37:0]     head_s;

    assign fifo_ne_s     = (occ_r != {CW{1'b0}});
    assign bus.cmd_ready = (occ_r < CW'(DEPTH)) && !rst;
    assign push_s        = bus.cmd_valid && bus.cmd_ready;
    assign res_hs_s      = res_valid_r && bus.res_ready;
    assign head_s        = mem_r[rd_ptr_r];

    assign bus.sh_dir    = sh_dir_r;
    assign bus.sh_amt    = sh_amt_r;
    assign bus.d_in      = d_in_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_count = res_count_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fifo_ne_s) state_nxt_s = ISSUE;
                else           state_nxt_s = IDLE;
            end
            ISSUE: state_nxt_s = HOLD;
            HOLD: begin
                if (bus.res_ready) begin
                    if (fifo_ne_s) state_nxt_s = ISSUE;
                    else           state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        pop_s     = 1'b0;
        capture_s = 1'b0;
        res_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fifo_ne_s) pop_s = 1'b1;
                else           pop_s = 1'b0;
            end
            ISSUE: capture_s = 1'b1;
            HOLD: begin
                if (bus.res_ready) begin
                    res_clr_s = 1'b1;
                    pop_s     = fifo_ne_s;
                end else begin
                    res_clr_s = 1'b0;
                    pop_s     = 1'b0;
                end
            end
            default: begin
                pop_s     = 1'b0;
                capture_s = 1'b0;
                res_clr_s = 1'b0;
            end
        endcase
    end

    // FIFO storage; push is already gated off during reset through cmd_ready.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.cmd_dir, bus.cmd_amt, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + CW'(1);
                2'b01:   occ_r <= occ_r - CW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Issue registers feeding the shifter; held until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_dir_r <= 1'b0;
            sh_amt_r <= 5'd0;
            d_in_r   <= 32'd0;
        end else if (pop_s) begin
            sh_dir_r <= head_s[37];
            sh_amt_r <= head_s[36:32];
            d_in_r   <= head_s[31:0];
        end
    end

    // Result capture, handshake and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 32'd0;
            res_count_r <= 16'd0;
        end else begin
            if (capture_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= bus.d_out;
            end else if (res_clr_s) begin
                res_valid_r <= 1'b0;
            end
            if (res_hs_s) res_count_r <= res_count_r + 16'd1;
        end
    end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench: queue-based reference model compared every cycle, a result
// scoreboard, and directed cases with hand-computed expectations.
module tb_shift_cmd_sequencer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    shift_cmd_if bus();

    shift_cmd_sequencer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] shf(input logic dir, input logic [4:0] amt, input logic [31:0] d);
        if (dir) return 32'($signed(d) >>> amt);
        else     return d << amt;
    endfunction

    assign bus.d_out = shf(bus.sh_dir, bus.sh_amt, bus.d_in);

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc_n    = 0;
    bit          chk_en   = 1'b0;

    logic [37:0] q[$];
    logic [31:0] sb[$];
    logic [31:0] got[$];
    int          got_cyc[$];
    bit          m_iss, m_rv;
    logic        m_dir;
    logic [4:0]  m_amt;
    logic [31:0] m_d, m_rd;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Reference model: FIFO as a queue, one in-flight command, one held result.
    always @(posedge clk) begin
        logic [37:0] c;
        bit acc;
        cyc_n++;
        if (rst) begin
            q.delete(); sb.delete();
            m_iss = 1'b0; m_rv = 1'b0; m_rd = 32'd0; m_cnt = 16'd0;
            m_dir = 1'b0; m_amt = 5'd0; m_d = 32'd0;
        end else begin
            acc = bus.cmd_valid && (q.size() < DEPTH);
            if (!m_iss) begin
                if (q.size() > 0) begin
                    c = q.pop_front(); m_dir = c[37]; m_amt = c[36:32]; m_d = c[31:0];
                    m_iss = 1'b1;
                end
            end else if (!m_rv) begin
                m_rv = 1'b1;
                m_rd = shf(m_dir, m_amt, m_d);
            end else if (bus.res_ready) begin
                m_cnt = m_cnt + 16'd1;
                m_rv  = 1'b0;
                if (q.size() > 0) begin
                    c = q.pop_front(); m_dir = c[37]; m_amt = c[36:32]; m_d = c[31:0];
                end else begin
                    m_iss = 1'b0;
                end
            end
            if (acc) begin
                q.push_back({bus.cmd_dir, bus.cmd_amt, bus.cmd_data});
                sb.push_back(shf(bus.cmd_dir, bus.cmd_amt, bus.cmd_data));
            end
        end
    end

    // Per-cycle compare against the model plus in-order result scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(bus.cmd_ready), 32'(!rst && (q.size() < DEPTH)));
            check("sh_dir", 32'(bus.sh_dir), 32'(m_dir));
            check("sh_amt", 32'(bus.sh_amt), 32'(m_amt));
            check("d_in", bus.d_in, m_d);
            check("res_valid", 32'(bus.res_valid), 32'(m_rv));
            check("res_data", bus.res_data, m_rd);
            check("res_count", 32'(bus.res_count), 32'(m_cnt));
            if (!rst && bus.res_valid && bus.res_ready) begin
                got.push_back(bus.res_data);
                got_cyc.push_back(cyc_n);
                if (sb.size() == 0) check("sb_unexpected", bus.res_data, 32'hDEAD_BEEF);
                else                check("sb_order", bus.res_data, sb.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d, input logic [4:0] a, input logic [31:0] x);
        int k = 0;
        bus.cmd_dir = d; bus.cmd_amt = a; bus.cmd_data = x; bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && k < 200) begin
            cyc();
            k++;
        end
        check("push_ready", 32'(bus.cmd_ready), 32'd1);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input int bound);
        int k = 0;
        while (got.size() < n && k < bound) begin
            cyc();
            k++;
        end
        check("wait_results", 32'(got.size()), 32'(n));
    endtask

    initial begin
        int acc;
        int k;
        logic [31:0] hold;

        rst = 1'b1; bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_amt = 5'd0;
        bus.cmd_data = 32'd0; bus.res_ready = 1'b0;
        cyc();
        chk_en = 1'b1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_count", 32'(bus.res_count), 32'd0);
        check("rst_d_in", bus.d_in, 32'd0);

        // Single command latency: ASR 0x80000000 by 4.
        bus.res_ready = 1'b1;
        got.delete(); got_cyc.delete();
        bus.cmd_dir = 1'b1; bus.cmd_amt = 5'd4; bus.cmd_data = 32'h8000_0000; bus.cmd_valid = 1'b1;
        check("lat_ready", 32'(bus.cmd_ready), 32'd1);
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        check("lat_sh_amt", 32'(bus.sh_amt), 32'd4);
        check("lat_d_in", bus.d_in, 32'h8000_0000);
        check("lat_no_res_yet", 32'(bus.res_valid), 32'd0);
        cyc();
        check("lat_res_valid", 32'(bus.res_valid), 32'd1);
        check("lat_res_data", bus.res_data, 32'hF800_0000);
        cyc();
        check("lat_res_count", 32'(bus.res_count), 32'd1);

        // Back-to-back LSL of 1 by 0, 1, 31.
        got.delete(); got_cyc.delete();
        push(1'b0, 5'd0, 32'd1);
        push(1'b0, 5'd1, 32'd1);
        push(1'b0, 5'd31, 32'd1);
        wait_got(3, 40);
        if (got.size() >= 3) begin
            check("b2b_r0", got[0], 32'h0000_0001);
            check("b2b_r1", got[1], 32'h0000_0002);
            check("b2b_r2", got[2], 32'h8000_0000);
            check("b2b_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd2);
            check("b2b_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd2);
        end

        // Backpressure: exactly DEPTH+1 accepted while results are stalled.
        bus.res_ready = 1'b0;
        got.delete(); got_cyc.delete();
        acc = 0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.cmd_dir = 1'b0; bus.cmd_amt = 5'(acc); bus.cmd_data = 32'(acc + 1);
            if (bus.cmd_ready) acc++;
            cyc();
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'(DEPTH + 1));
        check("bp_ready_low", 32'(bus.cmd_ready), 32'd0);
        hold = bus.res_data;
        check("bp_first_res", hold, 32'h0000_0001);
        cyc(); cyc(); cyc();
        check("bp_res_stable", bus.res_data, hold);
        bus.res_ready = 1'b1;
        wait_got(5, 60);
        if (got.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("bp_result", got[i], 32'(i + 1) << i);
        end
        cyc();
        check("bp_ready_back", 32'(bus.cmd_ready), 32'd1);

        // Sign-extension corners of ASR by 31.
        got.delete(); got_cyc.delete();
        push(1'b1, 5'd31, 32'h4000_0000);
        push(1'b1, 5'd31, 32'h8000_0000);
        wait_got(2, 40);
        if (got.size() >= 2) begin
            check("asr31_pos", got[0], 32'h0000_0000);
            check("asr31_neg", got[1], 32'hFFFF_FFFF);
        end

        // Reset with a held result and three queued commands.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, 5'(i), 32'h0000_0010);
        k = 0;
        while (!bus.res_valid && k < 20) begin
            cyc();
            k++;
        end
        check("mid_res_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_res_data", bus.res_data, 32'd0);
        check("mid_rst_d_in", bus.d_in, 32'd0);
        check("mid_rst_sh_amt", 32'(bus.sh_amt), 32'd0);
        check("mid_rst_count", 32'(bus.res_count), 32'd0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        got.delete(); got_cyc.delete();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check("mid_rst_no_stale", 32'(got.size()), 32'd0);
        check("mid_rst_count_hold", 32'(bus.res_count), 32'd0);

        // Random soak: 1000 commands with random consumer backpressure.
        got.delete(); got_cyc.delete();
        acc = 0;
        k = 0;
        while (got.size() < 1000 && k < 20000) begin
            bus.cmd_dir   = 1'($urandom);
            bus.cmd_amt   = 5'($urandom);
            bus.cmd_data  = $urandom;
            bus.res_ready = 1'($urandom_range(0, 1));
            bus.cmd_valid = (acc < 1000);
            if (bus.cmd_valid && bus.cmd_ready) acc++;
            cyc();
            k++;
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        check("soak_results", 32'(got.size()), 32'd1000);
        cyc();
        check("soak_count", 32'(bus.res_count), 32'd1000);
        check("soak_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
